// File: rtl/sseg_scan_driver_pkg.sv
// Shared display constants: blank/off codes, dash code and the ten active-low digit glyphs.
// Latency: none (constants only). Backpressure: none.
// Glyph bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package sseg_scan_driver_pkg;

    localparam logic [6:0] SSEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF  = 4'hF;
    localparam logic [3:0] CODE_DASH  = 4'hA;

    localparam logic [6:0] GLYPH_0    = 7'b1000000;
    localparam logic [6:0] GLYPH_1    = 7'b1111001;
    localparam logic [6:0] GLYPH_2    = 7'b0100100;
    localparam logic [6:0] GLYPH_3    = 7'b0110000;
    localparam logic [6:0] GLYPH_4    = 7'b0011001;
    localparam logic [6:0] GLYPH_5    = 7'b0010010;
    localparam logic [6:0] GLYPH_6    = 7'b0000010;
    localparam logic [6:0] GLYPH_7    = 7'b1111000;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0010000;
    localparam logic [6:0] GLYPH_DASH = 7'b0111111;

endpackage

// File: rtl/sseg_decoder.sv
// Combinational BCD nibble to active-low 7-segment glyph; 4'hA is a dash, 4'hB-4'hF blank.
// Latency: 0 cycles. Backpressure: none.
// Pure lookup, no state.
module sseg_decoder
    import sseg_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SSEG_BLANK;
        case (code)
            4'd0:      glyph = GLYPH_0;
            4'd1:      glyph = GLYPH_1;
            4'd2:      glyph = GLYPH_2;
            4'd3:      glyph = GLYPH_3;
            4'd4:      glyph = GLYPH_4;
            4'd5:      glyph = GLYPH_5;
            4'd6:      glyph = GLYPH_6;
            4'd7:      glyph = GLYPH_7;
            4'd8:      glyph = GLYPH_8;
            4'd9:      glyph = GLYPH_9;
            CODE_DASH: glyph = GLYPH_DASH;
            default:   glyph = SSEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// 4-digit common-anode scan driver with per-frame snapshot, blink and optional LEADING_ZERO_BLANK_EN.
// Latency: outputs registered 1 cycle behind (cnt,idx); inputs take effect on the next frame.
// Backpressure: none; inputs are sampled once per frame and ignored otherwise.
module sseg_scan_driver
    import sseg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;
    logic [15:0]      shadow_digits;
    logic [3:0]       shadow_dp;
    logic [3:0]       shadow_blink;

    logic       digit_end;
    logic       frame_end;
    logic [3:0] cur_code;
    logic [6:0] cur_glyph;
    logic       suppress;

    assign digit_end = (cnt == CNT_LAST);
    assign frame_end = digit_end && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            frame_cnt     <= '0;
            blink_phase   <= 1'b0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_blink  <= '0;
        end else begin
            if (digit_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Snapshot on the last cycle of digit 3 so a whole frame shows one consistent value.
            if (frame_end) begin
                shadow_digits <= digits;
                shadow_dp     <= dp_mask;
                shadow_blink  <= blink_mask;
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign cur_code = shadow_digits[{idx, 2'b00} +: 4];

    sseg_decoder u_decoder (
        .code  (cur_code),
        .glyph (cur_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero only if it and every digit to its left are zero; digit 0 always shows.
    logic [3:0] lead_zero;
    always_comb begin
        lead_zero    = '0;
        lead_zero[3] = (shadow_digits[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (shadow_digits[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (shadow_digits[7:4] == 4'd0);
    end
    assign suppress = (shadow_blink[idx] && blink_phase) || lead_zero[idx];
`else
    assign suppress = shadow_blink[idx] && blink_phase;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            an   <= ANODE_OFF;
            sseg <= SSEG_BLANK;
            dp   <= 1'b1;
        end else begin
            an   <= ~(4'b0001 << idx);
            sseg <= suppress ? SSEG_BLANK : cur_glyph;
            dp   <= ~shadow_dp[idx];
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with REFRESH_DIV=4, BLINK_FRAMES=2 (16-cycle frames).
// Latency: expects outputs one cycle after each scan state. Backpressure: n/a.
// Expected glyphs are hand-written constants; leading-zero expectations follow LEADING_ZERO_BLANK_EN.
module tb_sseg_scan_driver;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZL = BL;
`else
    localparam logic [6:0] ZL = G0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp)
    );

    // Hold reset for n edges, checking blank outputs after each, then release at a falling edge.
    task automatic apply_reset(input string name, input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            n_checks++;
            if ({an, sseg, dp} !== {4'b1111, 7'b1111111, 1'b1})
                $display("FAIL %s cyc %0d: got an=%b sseg=%b dp=%b, want an=1111 sseg=1111111 dp=1",
                         name, k, an, sseg, dp);
            else
                n_pass++;
        end
        rst = 1'b0;
    endtask

    // Check n_cyc cycles of a frame; exp_seg = {d3,d2,d1,d0} glyphs, exp_dp = lit dp mask.
    task automatic check_frame(input string name, input logic [27:0] exp_seg, input logic [3:0] exp_dp,
                               input int n_cyc, input int chg_at, input logic [15:0] chg_dig);
        logic [3:0]  one;
        logic [11:0] exp_v;
        int          i;
        one = 4'b0001;
        for (int j = 0; j < n_cyc; j++) begin
            @(negedge clk);
            i     = j / 4;
            exp_v = {~(one << i), exp_seg[i*7 +: 7], ~exp_dp[i]};
            n_checks++;
            if ({an, sseg, dp} !== exp_v)
                $display("FAIL %s cyc %0d: got an=%b sseg=%b dp=%b, want an=%b sseg=%b dp=%b",
                         name, j, an, sseg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else
                n_pass++;
            if (j == chg_at) digits = chg_dig;
        end
    endtask

    task automatic test_reset();
        digits = '0; dp_mask = '0; blink_mask = '0;
        apply_reset("reset_hold", 3);
        check_frame("reset_f0", {ZL, ZL, ZL, G0}, 4'b0000, 16, -1, 16'h0);
    endtask

    task automatic test_scan();
        digits = '0;
        apply_reset("scan_rst", 1);
        check_frame("scan_f0", {ZL, ZL, ZL, G0}, 4'b0000, 16, 6, 16'h1234);
        check_frame("scan_f1", {G1, G2, G3, G4}, 4'b0000, 16, -1, 16'h1234);
    endtask

    task automatic test_tear_free();
        check_frame("tear_f2", {G1, G2, G3, G4}, 4'b0000, 16, 5, 16'h9999);
        check_frame("tear_f3", {G9, G9, G9, G9}, 4'b0000, 16, -1, 16'h9999);
    endtask

    task automatic test_dp();
        digits = 16'h1000; dp_mask = 4'b0100; blink_mask = 4'b0100;
        apply_reset("dp_rst", 1);
        check_frame("dp_f0", {ZL, ZL, ZL, G0}, 4'b0000, 16, -1, 16'h1000);
        check_frame("dp_f1_on", {G1, G0, G0, G0}, 4'b0100, 16, -1, 16'h1000);
        check_frame("dp_f2_off", {G1, BL, G0, G0}, 4'b0100, 16, -1, 16'h1000);
        check_frame("dp_f3_off", {G1, BL, G0, G0}, 4'b0100, 16, -1, 16'h1000);
        check_frame("dp_f4_on", {G1, G0, G0, G0}, 4'b0100, 16, -1, 16'h1000);
    endtask

    task automatic test_blink();
        digits = 16'h0008; dp_mask = '0; blink_mask = 4'b0001;
        apply_reset("blink_rst", 1);
        check_frame("blink_f0", {ZL, ZL, ZL, G0}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_f1_on", {ZL, ZL, ZL, G8}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_f2_off", {ZL, ZL, ZL, BL}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_f3_off", {ZL, ZL, ZL, BL}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_f4_on", {ZL, ZL, ZL, G8}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_f5_on", {ZL, ZL, ZL, G8}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_f6_off", {ZL, ZL, ZL, BL}, 4'b0000, 6, -1, 16'h0008);
        apply_reset("blink_midrst", 2);
        check_frame("blink_r0", {ZL, ZL, ZL, G0}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_r1_on", {ZL, ZL, ZL, G8}, 4'b0000, 16, -1, 16'h0008);
        check_frame("blink_r2_off", {ZL, ZL, ZL, BL}, 4'b0000, 16, -1, 16'h0008);
    endtask

    task automatic test_zero_blank();
        digits = 16'h0050; dp_mask = '0; blink_mask = '0;
        apply_reset("zb_rst", 1);
        check_frame("zb_f0", {ZL, ZL, ZL, G0}, 4'b0000, 16, -1, 16'h0050);
        check_frame("zb_f1_0050", {ZL, ZL, G5, G0}, 4'b0000, 16, 3, 16'h000A);
        check_frame("zb_f2_dash", {ZL, ZL, ZL, GD}, 4'b0000, 16, 3, 16'h0C00);
        check_frame("zb_f3_0c00", {ZL, BL, G0, G0}, 4'b0000, 16, -1, 16'h0C00);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_dp();
        test_blink();
        test_zero_blank();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
